// File: rtl/cpu_mem_responder.sv
// rtl/cpu_mem_responder.sv - program ROM / data RAM responder with host load port
// Fixed-latency pipelined reads, read-first RAM writes, sticky out-of-range flag.
module cpu_mem_responder #(
    parameter int ROM_DEPTH = 256,
    parameter int RAM_DEPTH = 256,
    parameter int ROM_LAT   = 2,
    parameter int RAM_LAT   = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] address_rom,
    output logic [15:0] q_rom,
    input  logic [15:0] address_ram,
    input  logic [15:0] data_ram,
    input  logic        wren_ram,
    output logic [15:0] q_ram,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [15:0] load_addr,
    input  logic [15:0] load_data,
    input  logic        load_done,
    output logic        cpu_run,
    output logic        oob_err
);

    localparam int ROM_AW = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1;
    localparam int RAM_AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
    localparam logic [16:0] ROM_DEPTH_W = 17'(ROM_DEPTH);
    localparam logic [16:0] RAM_DEPTH_W = 17'(RAM_DEPTH);

    typedef enum logic {S_LOAD = 1'b0, S_RUN = 1'b1} state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        w_load_we;
    logic        w_load_inr;
    logic        w_rom_inr;
    logic        w_ram_inr;
    logic [15:0] w_rom_rd;
    logic [15:0] w_ram_rd;
    logic        r_oob;

    logic [15:0] r_rom [0:ROM_DEPTH-1];
    logic [15:0] r_ram [0:RAM_DEPTH-1];
    logic [15:0] r_rom_pipe [0:ROM_LAT];
    logic [15:0] r_ram_pipe [0:RAM_LAT];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        load_ready   = 1'b0;
        cpu_run      = 1'b0;
        w_load_we    = 1'b0;
        case (r_state)
            S_LOAD: begin
                load_ready = 1'b1;
                w_load_we  = load_valid;
                if (load_done) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                cpu_run = 1'b1;
            end
            default: w_state_next = S_LOAD;
        endcase
    end

    // Range checks use the full 16-bit address; truncation to index width happens after.
    assign w_load_inr = {1'b0, load_addr}   < ROM_DEPTH_W;
    assign w_rom_inr  = {1'b0, address_rom} < ROM_DEPTH_W;
    assign w_ram_inr  = {1'b0, address_ram} < RAM_DEPTH_W;

    assign w_rom_rd = w_rom_inr ? r_rom[address_rom[ROM_AW-1:0]] : 16'h0000;
    assign w_ram_rd = w_ram_inr ? r_ram[address_ram[RAM_AW-1:0]] : 16'h0000;

    // Arrays carry no reset so program and data survive a CPU restart.
    always_ff @(posedge clock) begin
        if (w_load_we && w_load_inr) begin
            r_rom[load_addr[ROM_AW-1:0]] <= load_data;
        end
        if (wren_ram && w_ram_inr) begin
            r_ram[address_ram[RAM_AW-1:0]] <= data_ram;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i <= ROM_LAT; i++) begin
                r_rom_pipe[i] <= 16'h0000;
            end
            for (int j = 0; j <= RAM_LAT; j++) begin
                r_ram_pipe[j] <= 16'h0000;
            end
        end else begin
            r_rom_pipe[0] <= w_rom_rd;
            for (int i = 1; i <= ROM_LAT; i++) begin
                r_rom_pipe[i] <= r_rom_pipe[i-1];
            end
            r_ram_pipe[0] <= w_ram_rd;
            for (int j = 1; j <= RAM_LAT; j++) begin
                r_ram_pipe[j] <= r_ram_pipe[j-1];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_oob <= 1'b0;
        end else if (!w_rom_inr || !w_ram_inr || (w_load_we && !w_load_inr)) begin
            r_oob <= 1'b1;
        end
    end

    assign q_rom   = r_rom_pipe[ROM_LAT];
    assign q_ram   = r_ram_pipe[RAM_LAT];
    assign oob_err = r_oob;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// tb/tb_cpu_mem_responder.sv - directed self-checking bench for cpu_mem_responder
module tb_cpu_mem_responder;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] address_rom;
    logic [15:0] q_rom;
    logic [15:0] address_ram;
    logic [15:0] data_ram;
    logic        wren_ram;
    logic [15:0] q_ram;
    logic        load_valid;
    logic        load_ready;
    logic [15:0] load_addr;
    logic [15:0] load_data;
    logic        load_done;
    logic        cpu_run;
    logic        oob_err;

    int n_checks = 0;
    int n_fail   = 0;

    cpu_mem_responder dut (
        .clock       (clock),
        .reset       (reset),
        .address_rom (address_rom),
        .q_rom       (q_rom),
        .address_ram (address_ram),
        .data_ram    (data_ram),
        .wren_ram    (wren_ram),
        .q_ram       (q_ram),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .load_done   (load_done),
        .cpu_run     (cpu_run),
        .oob_err     (oob_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load_word(input logic [15:0] a, input logic [15:0] d);
        load_valid = 1'b1;
        load_addr  = a;
        load_data  = d;
        tick();
        load_valid = 1'b0;
    endtask

    // Sampling edge plus ROM_LAT further edges.
    task automatic read_rom(input string tag, input logic [15:0] a, input logic [15:0] exp);
        address_rom = a;
        tick();
        tick();
        tick();
        check(tag, q_rom, exp);
    endtask

    task automatic read_ram(input string tag, input logic [15:0] a, input logic [15:0] exp);
        address_ram = a;
        wren_ram    = 1'b0;
        tick();
        tick();
        check(tag, q_ram, exp);
    endtask

    task automatic write_ram(input logic [15:0] a, input logic [15:0] d);
        address_ram = a;
        data_ram    = d;
        wren_ram    = 1'b1;
        tick();
        wren_ram    = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        reset       = 1'b1;
        address_rom = 16'h0000;
        address_ram = 16'h0000;
        data_ram    = 16'h0000;
        wren_ram    = 1'b0;
        load_valid  = 1'b0;
        load_addr   = 16'h0000;
        load_data   = 16'h0000;
        load_done   = 1'b0;
        tick();
        tick();
        check("rst_cpu_run", {15'b0, cpu_run}, 16'h0000);
        check("rst_load_ready", {15'b0, load_ready}, 16'h0001);
        check("rst_oob", {15'b0, oob_err}, 16'h0000);
        check("rst_q_rom", q_rom, 16'h0000);
        check("rst_q_ram", q_ram, 16'h0000);
        reset = 1'b0;
        tick();

        load_word(16'd0, 16'h0002);
        load_word(16'd1, 16'h0007);
        load_word(16'd2, 16'h0002);
        load_word(16'd3, 16'h0005);
        load_word(16'd10, 16'hA00A);
        load_word(16'd11, 16'hB00B);
        load_word(16'd12, 16'hC00C);
        check("load_cpu_run_low", {15'b0, cpu_run}, 16'h0000);

        load_valid = 1'b1;
        load_addr  = 16'd7;
        load_data  = 16'hBEEF;
        load_done  = 1'b1;
        tick();
        load_valid = 1'b0;
        load_done  = 1'b0;
        check("run_cpu_run", {15'b0, cpu_run}, 16'h0001);
        check("run_load_ready", {15'b0, load_ready}, 16'h0000);

        read_rom("rom0", 16'd0, 16'h0002);
        read_rom("rom1", 16'd1, 16'h0007);
        read_rom("rom2", 16'd2, 16'h0002);
        read_rom("rom3", 16'd3, 16'h0005);
        read_rom("rom7_with_done", 16'd7, 16'hBEEF);

        address_rom = 16'd10;
        tick();
        address_rom = 16'd11;
        tick();
        address_rom = 16'd12;
        tick();
        check("stream10", q_rom, 16'hA00A);
        tick();
        check("stream11", q_rom, 16'hB00B);
        tick();
        check("stream12", q_rom, 16'hC00C);

        write_ram(16'd5, 16'h1111);
        address_ram = 16'd5;
        data_ram    = 16'h1234;
        wren_ram    = 1'b1;
        tick();
        wren_ram = 1'b0;
        tick();
        check("ram_read_first_old", q_ram, 16'h1111);
        tick();
        check("ram_read_new", q_ram, 16'h1234);

        write_ram(16'd0, 16'h0F0F);
        check("oob_before", {15'b0, oob_err}, 16'h0000);
        address_rom = 16'h0100;
        address_ram = 16'h0200;
        data_ram    = 16'hDEAD;
        wren_ram    = 1'b1;
        tick();
        wren_ram    = 1'b0;
        address_rom = 16'd0;
        address_ram = 16'd0;
        check("oob_set", {15'b0, oob_err}, 16'h0001);
        tick();
        tick();
        check("oob_rom_zero", q_rom, 16'h0000);
        check("oob_ram_unchanged", q_ram, 16'h0F0F);
        tick();
        check("oob_sticky", {15'b0, oob_err}, 16'h0001);

        load_word(16'd7, 16'h1111);
        read_rom("rom7_load_in_run", 16'd7, 16'hBEEF);
        check("run_stays", {15'b0, cpu_run}, 16'h0001);

        write_ram(16'd3, 16'h55AA);
        address_ram = 16'd3;
        tick();
        tick();
        check("ram3_before_reset", q_ram, 16'h55AA);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_q_rom", q_rom, 16'h0000);
        check("mid_rst_q_ram", q_ram, 16'h0000);
        check("mid_rst_cpu_run", {15'b0, cpu_run}, 16'h0000);
        check("mid_rst_load_ready", {15'b0, load_ready}, 16'h0001);
        check("mid_rst_oob", {15'b0, oob_err}, 16'h0000);
        tick();
        reset = 1'b0;
        read_ram("ram3_retained", 16'd3, 16'h55AA);
        read_rom("rom0_retained", 16'd0, 16'h0002);
        read_rom("rom3_retained", 16'd3, 16'h0005);
        read_rom("rom7_retained", 16'd7, 16'hBEEF);
        check("post_rst_cpu_run", {15'b0, cpu_run}, 16'h0000);
        check("post_rst_oob", {15'b0, oob_err}, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
